vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

- Generates 640x480@60 Hz VGA raster timing from the 50 MHz board clock.
- Drives the pixel-coordinate, active-region and sync interface that the game/pixel logic consumes.
- The game logic colours a pixel from `xPixel`/`yPixel` when `active_pixels` is high; this block owns everything upstream of that decision.
- It replaces a free-running reference timing path with a fully specified, synchronously reset generator.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  50 MHz system clock; sole clock.
- rst  in  1  Synchronous reset, active-high.
- vga_clk  out  1  25 MHz pixel clock to the DAC.
- hsync  out  1  Horizontal sync, active-low.
- vsync  out  1  Vertical sync, active-low.
- active_pixels  out  1  High inside the 640x480 visible region.
- xPixel  out  10  Horizontal counter, 0..799.
- yPixel  out  10  Vertical counter, 0..524.
- VGA_BLANK_N  out  1  Equals `active_pixels`.
- VGA_SYNC_N  out  1  Constant 0.
- frame_start  out  1  Present only with `VGA_FRAME_PULSE_EN`.

## Operation

- **Pixel enable:** `ce` register toggles every clk; reset value 0.
- **Pixel clock:** `vga_clk` = ~`ce`.
- **Counters:** `h_cnt` and `v_cnt` are 10-bit and advance only on edges where `ce`==1.
  - `h_cnt` wraps 799→0.
  - On that wrap, `v_cnt` increments; `v_cnt` wraps 524→0.
  - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
  - All comparisons are unsigned 10-bit.
- **Output registers** load every clk edge from the current counter state:
  - `xPixel` = h_cnt; `yPixel` = v_cnt.
  - `active_pixels` = (h_cnt<640)&&(v_cnt<480).
  - `hsync` = !(656<=h_cnt<=751).
  - `vsync` = !(490<=v_cnt<=491).
- **Reset values** (while `rst`): counters 0, `ce` 0, `vga_clk` 1, `xPixel` 0, `yPixel` 0, `hsync` 1, `vsync` 1, `active_pixels` 0, `VGA_BLANK_N` 0, `frame_start` 0.
- **Reset mid-frame:** abandons the frame immediately; no partial sync pulse is extended. Restart is identical to a power-on reset.

## Timing

- Outputs lag the counters by one clk. Each pixel's output window is 2 clks.
- `vga_clk` rises at the midpoint of each window, so the DAC samples stable data.
- First edge after `rst` falls: outputs show (0,0) with `active_pixels`=1. Pixel (1,0) appears 2 clks later.
- Line = 1600 clks. `hsync` low for 192 clks, starting when `xPixel` reads 656.
- Frame = 840000 clks. `vsync` low for 3200 clks, starting at (0,490).
- All outputs change together on the same clk edge; there are no combinational outputs except the constant `VGA_SYNC_N`.

## Configuration

- **`VGA_FRAME_PULSE_EN` defined:**
  - `frame_start` port exists.
  - It pulses high for exactly 1 clk on the first clk of each (0,0) output window, including the first window after reset.
  - Frame logic uses it instead of edge-detecting `vsync`.
- **Not defined:** the port and its logic are absent. All other behaviour is identical.

## Test plan

- **Reset hold:** hold `rst` 10 clks → `hsync`=1, `vsync`=1, `active_pixels`=0, `vga_clk`=1, `xPixel`=0, `yPixel`=0. Release → next edge `active_pixels`=1, `xPixel`=0, `yPixel`=0.
- **Line timing:** run 1 line → `xPixel` steps 0..799, 2 clks per value. `hsync` low exactly 192 clks starting at `xPixel`=656. `active_pixels` high for 1280 clks in lines 0..479.
- **Frame timing:** run 1 full frame → `yPixel` wraps 524→0 after 840000 clks. `vsync` low 3200 clks while `yPixel`∈{490,491}. 307200 active pixel windows counted.
- **Sampling alignment:** check every `vga_clk` rising edge → sampled `xPixel`/`active_pixels` equal the values loaded 1 clk earlier. No output transition coincides with a `vga_clk` rise.
- **Reset mid-operation:** assert `rst` 1 clk at (700,300) → outputs return to reset values. The sequence restarts from (0,0) with the same timing as the power-on case.
- **With `VGA_FRAME_PULSE_EN`:** run 3 frames → `frame_start` pulses 3 times, 1 clk wide, 840000 clks apart, each coinciding with `xPixel`=0, `yPixel`=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing from a 50 MHz clock, one pixel per two clks.
// Define VGA_FRAME_PULSE_EN to add the one-clk frame_start pulse at the first (0,0) window.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
   output logic       vga_clk,
   output logic       hsync,
   output logic       vsync,
   output logic       active_pixels,
   output logic [9:0] xPixel,
   output logic [9:0] yPixel,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N
`ifdef VGA_FRAME_PULSE_EN
   ,
   output logic       frame_start
`endif
);
   localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic       ce;
   logic [9:0] h_cnt, v_cnt;

   assign VGA_SYNC_N = 1'b0;

   // vga_clk is registered as the next ~ce so it rises mid-window with the other outputs stable
   always_ff @(posedge clk) begin
      if (rst) begin
         ce            <= 1'b0;
         vga_clk       <= 1'b1;
         h_cnt         <= '0;
         v_cnt         <= '0;
         xPixel        <= '0;
         yPixel        <= '0;
         hsync         <= 1'b1;
         vsync         <= 1'b1;
         active_pixels <= 1'b0;
         VGA_BLANK_N   <= 1'b0;
      end else begin
         ce            <= ~ce;
         vga_clk       <= ce;
         if (ce) begin
            h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 10'd1;
            if (h_cnt == H_LAST)
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
         end
         xPixel        <= h_cnt;
         yPixel        <= v_cnt;
         hsync         <= !(h_cnt >= HS_BEG && h_cnt <= HS_END);
         vsync         <= !(v_cnt >= VS_BEG && v_cnt <= VS_END);
         active_pixels <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
         VGA_BLANK_N   <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
      end
   end

`ifdef VGA_FRAME_PULSE_EN
   // !ce marks the first of the two clks that the (0,0) counter state is held
   always_ff @(posedge clk) begin
      if (rst) frame_start <= 1'b0;
      else     frame_start <= (h_cnt == '0) && (v_cnt == '0) && !ce;
   end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: full-size and shrunk-raster instances checked every clk against an arithmetic raster model.
// Build with VGA_FRAME_PULSE_EN defined to also check frame_start.
module tb_vga_timing_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic vc_a, hs_a, vs_a, ap_a, bn_a, sn_a;
   logic vc_b, hs_b, vs_b, ap_b, bn_b, sn_b;
   logic [9:0] x_a, y_a, x_b, y_b;
`ifdef VGA_FRAME_PULSE_EN
   logic fs_a, fs_b;
`endif
   int n = -1;
   int errors = 0, checks = 0;
   int act_a = 0, hlo_a = 0, act_b = 0, vlo_b = 0, fs_cnt_b = 0;
   bit first = 1'b1;

   always #10 clk = ~clk;

   vga_timing_gen dut_a (
      .clk(clk), .rst(rst), .vga_clk(vc_a), .hsync(hs_a), .vsync(vs_a),
      .active_pixels(ap_a), .xPixel(x_a), .yPixel(y_a),
      .VGA_BLANK_N(bn_a), .VGA_SYNC_N(sn_a)
`ifdef VGA_FRAME_PULSE_EN
      , .frame_start(fs_a)
`endif
   );

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dut_b (
      .clk(clk), .rst(rst), .vga_clk(vc_b), .hsync(hs_b), .vsync(vs_b),
      .active_pixels(ap_b), .xPixel(x_b), .yPixel(y_b),
      .VGA_BLANK_N(bn_b), .VGA_SYNC_N(sn_b)
`ifdef VGA_FRAME_PULSE_EN
      , .frame_start(fs_b)
`endif
   );

   // n = clk edges since reset release; the edge that sees rst low first is n=0
   always @(posedge clk) n <= rst ? -1 : n + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors <= 20)
            $display("FAIL %s at n=%0d: got %0d, expected %0d", name, n, got, exp);
      end
   endtask

   // {vga_clk, hsync, vsync, active, x[9:0], y[9:0], frame_start}
   function automatic logic [24:0] model(input int e, input int ha, hf, hs, hb, va, vf, vs, vb);
      int p, x, y;
      if (e < 0) return {1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0};
      p = e / 2;
      x = p % (ha + hf + hs + hb);
      y = (p / (ha + hf + hs + hb)) % (va + vf + vs + vb);
      return {e % 2 == 1, !(x >= ha + hf && x < ha + hf + hs), !(y >= va + vf && y < va + vf + vs),
              x < ha && y < va, 10'(x), 10'(y), x == 0 && y == 0 && e % 2 == 0};
   endfunction

   always @(negedge clk) begin
      logic [24:0] ea, eb;
      ea = model(n, 640, 16, 96, 48, 480, 10, 2, 33);
      eb = model(n, 16, 2, 4, 3, 12, 2, 2, 3);
      chk("a_vga_clk", vc_a, ea[24]);
      chk("a_hsync", hs_a, ea[23]);
      chk("a_vsync", vs_a, ea[22]);
      chk("a_active", ap_a, ea[21]);
      chk("a_blank_n", bn_a, ea[21]);
      chk("a_sync_n", sn_a, 0);
      chk("a_x", x_a, ea[20:11]);
      chk("a_y", y_a, ea[10:1]);
      chk("b_vga_clk", vc_b, eb[24]);
      chk("b_hsync", hs_b, eb[23]);
      chk("b_vsync", vs_b, eb[22]);
      chk("b_active", ap_b, eb[21]);
      chk("b_blank_n", bn_b, eb[21]);
      chk("b_x", x_b, eb[20:11]);
      chk("b_y", y_b, eb[10:1]);
`ifdef VGA_FRAME_PULSE_EN
      chk("a_frame_start", fs_a, ea[0]);
      chk("b_frame_start", fs_b, eb[0]);
      if (first && n >= 0) fs_cnt_b += int'(fs_b);
`endif
      if (first && n >= 0 && n < 1600) begin
         act_a += int'(ap_a);
         hlo_a += int'(!hs_a);
      end
      if (first && n >= 0 && n < 950) begin
         act_b += int'(ap_b);
         vlo_b += int'(!vs_b);
      end
   end

   task automatic wait_n(input int k);
      while (n < k) @(negedge clk);
   endtask

   initial begin
      repeat (10) @(negedge clk);
      chk("rst_hsync", hs_a, 1);
      chk("rst_vsync", vs_a, 1);
      chk("rst_active", ap_a, 0);
      chk("rst_vga_clk", vc_a, 1);
      chk("rst_x", x_a, 0);
      chk("rst_y", y_a, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("first_x", x_a, 0);
      chk("first_y", y_a, 0);
      chk("first_active", ap_a, 1);
      chk("first_vga_clk", vc_a, 0);
      wait_n(2);
      chk("second_x", x_a, 1);
      wait_n(950);
      chk("b_wrap_x", x_b, 0);
      chk("b_wrap_y", y_b, 0);
`ifdef VGA_FRAME_PULSE_EN
      chk("b_wrap_fs", fs_b, 1);
`endif
      wait_n(1311);
      chk("x655_hsync", hs_a, 1);
      wait_n(1312);
      chk("x656", x_a, 656);
      chk("x656_hsync", hs_a, 0);
      wait_n(1600);
      chk("line1_x", x_a, 0);
      chk("line1_y", y_a, 1);
      wait_n(4601);
      chk("mid_x", x_a, 700);
      chk("mid_y", y_a, 2);
      first = 1'b0;
      chk("line0_active_clks", act_a, 1280);
      chk("line0_hsync_low_clks", hlo_a, 192);
      chk("b_frame_active_clks", act_b, 384);
      chk("b_frame_vsync_low_clks", vlo_b, 100);
`ifdef VGA_FRAME_PULSE_EN
      chk("b_frame_start_pulses", fs_cnt_b, 5);
`endif
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_active", ap_a, 0);
      chk("midrst_hsync", hs_a, 1);
      chk("midrst_vga_clk", vc_a, 1);
      chk("midrst_x", x_a, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("restart_x", x_a, 0);
      chk("restart_y", y_a, 0);
      chk("restart_active", ap_a, 1);
      wait_n(3300);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
